// File: rtl/bram_stream_loader.sv
// bram_stream_loader
// Loads a host byte stream into MicroBlaze local memory through BRAM port B.
// Bytes are packed big-endian (first byte in bits 0:7) into 32-bit words that
// are written at consecutive word addresses from a word-aligned base. A
// running sum of written words is kept; when C_VERIFY=1 the image is read
// back and its sum compared against the write-side checksum.
//
// Ports (bit 0 is the MSB on every bus):
//   Clk, Rst            block clock, synchronous active-high reset
//   Start               begin a load (IDLE only); Base_Addr/Word_Count sampled with it
//   S_Data/S_Valid/S_Ready  byte stream, accepted when S_Valid && S_Ready
//   BRAM_*_B            BRAM port B (clock/reset forwarded, EN, WEN, Addr, Dout, Din)
//   Busy                high outside IDLE
//   Done                one-cycle completion pulse
//   Verify_Err          read-back sum mismatch, held until the next accepted Start
//   Checksum            sum of written words mod 2^32, held until the next accepted Start
//
// state      | meaning
// -----------+-----------------------------------------------
// IDLE       | waiting for Start
// COLLECT    | accepting stream bytes into the word buffer
// WRITE      | writing the assembled word to BRAM
// VERIFY_RD  | issuing a read-back of word index
// VERIFY_CMP | accumulating the read-back word
// DONE       | one-cycle completion pulse

module bram_stream_loader #(
  parameter int C_PORT_AWIDTH = 32,
  parameter int C_PORT_DWIDTH = 32,
  parameter int C_NUM_WE      = 4,
  parameter int C_VERIFY      = 1
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     Start,
  input  logic [0:C_PORT_AWIDTH-1] Base_Addr,
  input  logic [0:15]              Word_Count,
  input  logic [0:7]               S_Data,
  input  logic                     S_Valid,
  output logic                     S_Ready,
  output logic                     BRAM_Rst_B,
  output logic                     BRAM_Clk_B,
  output logic                     BRAM_EN_B,
  output logic [0:C_NUM_WE-1]      BRAM_WEN_B,
  output logic [0:C_PORT_AWIDTH-1] BRAM_Addr_B,
  output logic [0:C_PORT_DWIDTH-1] BRAM_Dout_B,
  input  logic [0:C_PORT_DWIDTH-1] BRAM_Din_B,
  output logic                     Busy,
  output logic                     Done,
  output logic                     Verify_Err,
  output logic [0:C_PORT_DWIDTH-1] Checksum
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_COLLECT    = 3'd1;
  localparam logic [2:0] S_WRITE      = 3'd2;
  localparam logic [2:0] S_VERIFY_RD  = 3'd3;
  localparam logic [2:0] S_VERIFY_CMP = 3'd4;
  localparam logic [2:0] S_DONE       = 3'd5;

  logic [2:0]               state_q;
  logic [0:C_PORT_AWIDTH-1] base_q;
  logic [0:15]              count_q;
  logic [0:15]              idx_q;
  logic [0:15]              idx_inc;
  logic [1:0]               byte_cnt_q;
  logic [0:C_PORT_DWIDTH-1] word_q;
  logic [0:C_PORT_DWIDTH-1] word_next;
  logic [0:C_PORT_DWIDTH-1] rd_sum_q;
  logic [0:C_PORT_DWIDTH-1] rd_sum_next;
  logic [0:C_PORT_AWIDTH-1] addr_q;
  logic [0:C_PORT_DWIDTH-1] dout_q;
  logic [0:C_PORT_DWIDTH-1] checksum_q;
  logic                     verify_err_q;
  logic [0:C_PORT_AWIDTH-1] addr_cur;
  logic [0:C_PORT_AWIDTH-1] addr_inc;

  assign idx_inc     = idx_q + 16'd1;
  // Address arithmetic deliberately wraps at 2^C_PORT_AWIDTH.
  assign addr_cur    = base_q + C_PORT_AWIDTH'({idx_q, 2'b00});
  assign addr_inc    = base_q + C_PORT_AWIDTH'({idx_inc, 2'b00});
  // Shift-in packing leaves the first accepted byte in bits 0:7 after four bytes.
  assign word_next   = {word_q[8:C_PORT_DWIDTH-1], S_Data};
  assign rd_sum_next = rd_sum_q + BRAM_Din_B;

  assign BRAM_Rst_B  = Rst;
  assign BRAM_Clk_B  = Clk;
  assign S_Ready     = (state_q == S_COLLECT);
  assign BRAM_EN_B   = (state_q == S_WRITE) || (state_q == S_VERIFY_RD);
  assign BRAM_WEN_B  = {C_NUM_WE{state_q == S_WRITE}};
  assign BRAM_Addr_B = addr_q;
  assign BRAM_Dout_B = dout_q;
  assign Busy        = (state_q != S_IDLE);
  assign Done        = (state_q == S_DONE);
  assign Verify_Err  = verify_err_q;
  assign Checksum    = checksum_q;

  // Addr/Dout are registered and loaded on the transition into an access
  // state so they are stable for the whole access cycle and hold afterwards.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      count_q      <= '0;
      idx_q        <= '0;
      byte_cnt_q   <= '0;
      word_q       <= '0;
      rd_sum_q     <= '0;
      addr_q       <= '0;
      dout_q       <= '0;
      checksum_q   <= '0;
      verify_err_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            base_q       <= {Base_Addr[0:C_PORT_AWIDTH-3], 2'b00};
            count_q      <= Word_Count;
            idx_q        <= '0;
            byte_cnt_q   <= '0;
            rd_sum_q     <= '0;
            checksum_q   <= '0;
            verify_err_q <= 1'b0;
            state_q      <= (Word_Count == 16'd0) ? S_DONE : S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (S_Valid) begin
            word_q     <= word_next;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              dout_q  <= word_next;
              addr_q  <= addr_cur;
              state_q <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          checksum_q <= checksum_q + dout_q;
          if (idx_inc == count_q) begin
            if (C_VERIFY != 0) begin
              idx_q   <= '0;
              addr_q  <= base_q;
              state_q <= S_VERIFY_RD;
            end else begin
              idx_q   <= idx_inc;
              state_q <= S_DONE;
            end
          end else begin
            idx_q   <= idx_inc;
            state_q <= S_COLLECT;
          end
        end
        S_VERIFY_RD: begin
          state_q <= S_VERIFY_CMP;
        end
        S_VERIFY_CMP: begin
          rd_sum_q <= rd_sum_next;
          if (idx_inc == count_q) begin
            idx_q        <= idx_inc;
            verify_err_q <= (rd_sum_next != checksum_q);
            state_q      <= S_DONE;
          end else begin
            idx_q   <= idx_inc;
            addr_q  <= addr_inc;
            state_q <= S_VERIFY_RD;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_stream_loader.sv
// Testbench for bram_stream_loader: directed loads with a BRAM port-B model.
// Expected BRAM accesses and Done results are queued when a load is issued;
// a monitor on the falling edge pops and compares whenever the DUT asserts
// EN or Done.

module tb_bram_stream_loader;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, s_valid, s_ready;
  logic [0:31] base_addr;
  logic [0:15] word_count;
  logic [0:7]  s_data;
  logic        bram_rst, bram_clk, en;
  logic [0:3]  wen;
  logic [0:31] addr, dout, din;
  logic        busy, done, verr;
  logic [0:31] cks;

  bram_stream_loader #(
    .C_PORT_AWIDTH(32), .C_PORT_DWIDTH(32), .C_NUM_WE(4), .C_VERIFY(1)
  ) dut (
    .Clk(clk), .Rst(rst), .Start(start), .Base_Addr(base_addr),
    .Word_Count(word_count), .S_Data(s_data), .S_Valid(s_valid),
    .S_Ready(s_ready), .BRAM_Rst_B(bram_rst), .BRAM_Clk_B(bram_clk),
    .BRAM_EN_B(en), .BRAM_WEN_B(wen), .BRAM_Addr_B(addr),
    .BRAM_Dout_B(dout), .BRAM_Din_B(din), .Busy(busy), .Done(done),
    .Verify_Err(verr), .Checksum(cks)
  );

  typedef struct {bit wr; logic [31:0] a; logic [31:0] d; int c;} acc_t;
  typedef struct {logic [31:0] k; bit e; int c;} done_t;

  acc_t        acc_q[$];
  done_t       done_q[$];
  acc_t        mon_a;
  done_t       mon_d;
  logic [7:0]  bq[$];
  logic [31:0] mem [logic [31:0]];

  int n_tests = 0, n_fail = 0;
  int cyc = 0, t0 = 0, en_cnt = 0, done_cnt = 0, exp_done = 0;
  bit fault = 1'b0, chk_busy = 1'b0, prev_done = 1'b0;
  int e0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // BRAM port-B model with one-cycle registered read and optional bit flip.
  always @(posedge clk) begin
    if (en) begin
      if (wen == 4'hF) mem[addr] = dout;
      else din <= (mem.exists(addr) ? mem[addr] : 32'h0) ^
                  ((fault && addr == 32'h104) ? 32'h1 : 32'h0);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      if (chk_busy && cyc == t0 + 1) begin
        check("busy_rise", busy, 1);
        chk_busy = 1'b0;
      end
      if (prev_done) check("busy_fall", busy, 0);
      if (en) begin
        en_cnt++;
        if (acc_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_access: addr %h wen %b, no access required", addr, wen);
        end else begin
          mon_a = acc_q.pop_front();
          check("wen", wen, mon_a.wr ? 32'hF : 32'h0);
          check("addr", addr, mon_a.a);
          if (mon_a.wr) check("wdata", dout, mon_a.d);
          check("access_cycle", cyc - t0, mon_a.c);
        end
      end
      if (done) begin
        done_cnt++;
        if (done_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_done: Done high, no completion required");
        end else begin
          mon_d = done_q.pop_front();
          check("checksum", cks, mon_d.k);
          check("verify_err", verr, mon_d.e);
          check("done_cycle", cyc - t0, mon_d.c);
        end
      end
      prev_done = done;
    end
  end

  task automatic exp_acc(input bit wr, input logic [31:0] a, input logic [31:0] d, input int c);
    acc_t x;
    x.wr = wr; x.a = a; x.d = d; x.c = c;
    acc_q.push_back(x);
  endtask

  task automatic exp_fin(input logic [31:0] k, input bit e, input int c);
    done_t x;
    x.k = k; x.e = e; x.c = c;
    done_q.push_back(x);
    exp_done++;
  endtask

  // Called at a falling edge; returns at the falling edge inside cycle 1.
  task automatic start_load(input logic [31:0] b, input logic [15:0] n);
    base_addr  = b;
    word_count = n;
    start      = 1'b1;
    t0         = cyc;
    chk_busy   = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_bytes(input bit gap);
    int i = 0, k = 0;
    while (i < bq.size() && k < 400) begin
      if (gap && k[0]) s_valid = 1'b0;
      else begin s_valid = 1'b1; s_data = bq[i]; end
      @(posedge clk);
      if (s_valid && s_ready) i++;
      @(negedge clk);
      start = 1'b0;
      k++;
    end
    s_valid = 1'b0;
    if (i < bq.size()) begin
      n_tests++; n_fail++;
      $display("FAIL byte_timeout: accepted %0d, required %0d", i, bq.size());
    end
  endtask

  task automatic wait_done(input int budget);
    int i = 0;
    while (done_cnt < exp_done && i < budget) begin @(negedge clk); i++; end
    if (done_cnt < exp_done) begin
      n_tests++; n_fail++;
      $display("FAIL done_timeout: done count %0d, required %0d", done_cnt, exp_done);
      done_cnt = exp_done;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_vals();
    check("rst_s_ready", s_ready, 0);
    check("rst_en", en, 0);
    check("rst_wen", wen, 0);
    check("rst_addr", addr, 0);
    check("rst_dout", dout, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_verr", verr, 0);
    check("rst_checksum", cks, 0);
    check("rst_bram_rst", bram_rst, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
    base_addr = '0; word_count = '0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    @(negedge clk);

    // Nominal two-word load with verify.
    exp_acc(1, 32'h100, 32'h01020304, 5);
    exp_acc(1, 32'h104, 32'h05060708, 10);
    exp_acc(0, 32'h100, 0, 11);
    exp_acc(0, 32'h104, 0, 13);
    exp_fin(32'h06080A0C, 0, 15);
    bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    start_load(32'h100, 16'd2);
    send_bytes(0);
    wait_done(60);

    // Reset held mid-idle with a byte offered.
    rst = 1'b1; s_valid = 1'b1; s_data = 8'h55;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst = 1'b0; s_valid = 1'b0;
    @(negedge clk);

    // Backpressure: S_Valid low on alternate cycles.
    exp_acc(1, 32'h100, 32'h01020304, 8);
    exp_acc(1, 32'h104, 32'h05060708, 16);
    exp_acc(0, 32'h100, 0, 17);
    exp_acc(0, 32'h104, 0, 19);
    exp_fin(32'h06080A0C, 0, 21);
    start_load(32'h100, 16'd2);
    send_bytes(1);
    wait_done(60);

    // Read-back corruption at 0x104.
    fault = 1'b1;
    exp_acc(1, 32'h100, 32'h01020304, 5);
    exp_acc(1, 32'h104, 32'h05060708, 10);
    exp_acc(0, 32'h100, 0, 11);
    exp_acc(0, 32'h104, 0, 13);
    exp_fin(32'h06080A0C, 1, 15);
    start_load(32'h100, 16'd2);
    send_bytes(0);
    wait_done(60);
    fault = 1'b0;

    // Zero-length load.
    e0 = en_cnt;
    exp_fin(32'h0, 0, 1);
    start_load(32'h40, 16'd0);
    wait_done(20);
    check("zero_len_no_en", en_cnt - e0, 0);

    // Address wrap past 0xFFFFFFFC.
    exp_acc(1, 32'hFFFFFFFC, 32'h11121314, 5);
    exp_acc(1, 32'h00000000, 32'h15161718, 10);
    exp_acc(0, 32'hFFFFFFFC, 0, 11);
    exp_acc(0, 32'h00000000, 0, 13);
    exp_fin(32'h26282A2C, 0, 15);
    bq = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    start_load(32'hFFFFFFFC, 16'd2);
    send_bytes(0);
    wait_done(60);

    // Misaligned base is word-aligned down.
    exp_acc(1, 32'h100, 32'hA1A2A3A4, 5);
    exp_acc(0, 32'h100, 0, 6);
    exp_fin(32'hA1A2A3A4, 0, 8);
    bq = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    start_load(32'h103, 16'd1);
    send_bytes(0);
    wait_done(40);

    // Abort after two bytes: no BRAM access may follow.
    e0 = en_cnt;
    bq = '{8'h01, 8'h02};
    start_load(32'h200, 16'd1);
    send_bytes(0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_no_en", en_cnt - e0, 0);
    check("abort_busy", busy, 0);

    // Restart, with a stray Start while busy that must be ignored.
    exp_acc(1, 32'h0, 32'hAABBCCDD, 5);
    exp_acc(0, 32'h0, 0, 6);
    exp_fin(32'hAABBCCDD, 0, 8);
    bq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    start_load(32'h0, 16'd1);
    start = 1'b1; base_addr = 32'h500; word_count = 16'd5;
    send_bytes(0);
    start = 1'b0;
    wait_done(40);
    repeat (10) @(negedge clk);

    check("acc_queue_empty", acc_q.size(), 0);
    check("done_queue_empty", done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_stream_loader.md
# bram_stream_loader

Upstream companion to the MicroBlaze local-memory BRAM block. It drives BRAM port B and writes a host byte stream into processor memory before boot or between runs. Bytes are packed big-endian into 32-bit words and written at consecutive word addresses. A running checksum is kept, and an optional read-back pass confirms the image landed intact.

## Interface
Parameters:
- C_PORT_AWIDTH, 32, BRAM address width
- C_PORT_DWIDTH, 32, BRAM data width (fixed at 32)
- C_NUM_WE, 4, byte write enables
- C_VERIFY, 1, 1 = read-back verify pass after load, 0 = skip

Ports. Bit 0 is the MSB on all buses. Clk is the only clock; Rst is synchronous and active-high.
- Clk  in  1  block clock; also forwarded on BRAM_Clk_B
- Rst  in  1  synchronous active-high reset
- Start  in  1  begin a load; sampled only in IDLE
- Base_Addr  in  [0:31]  byte start address; bits 30:31 ignored (word aligned); sampled on Start
- Word_Count  in  [0:15]  words to load; sampled on Start
- S_Data  in  [0:7]  stream byte
- S_Valid  in  1  byte valid
- S_Ready  out  1  byte accepted when S_Valid && S_Ready
- BRAM_Rst_B  out  1  equals Rst
- BRAM_Clk_B  out  1  equals Clk
- BRAM_EN_B  out  1  port enable
- BRAM_WEN_B  out  [0:3]  byte write enables
- BRAM_Addr_B  out  [0:31]  byte address
- BRAM_Dout_B  out  [0:31]  write data to BRAM
- BRAM_Din_B  in  [0:31]  read data from BRAM, one cycle after an EN read
- Busy  out  1  high in any state other than IDLE
- Done  out  1  one-cycle pulse at completion
- Verify_Err  out  1  read-back sum mismatch; held until next accepted Start
- Checksum  out  [0:31]  sum of written words mod 2^32; held until next accepted Start

## Operation
- States: IDLE, COLLECT, WRITE, VERIFY_RD, VERIFY_CMP, DONE.
- IDLE:
  - S_Ready=0.
  - On Start: latch base (low 2 bits cleared) and count; clear Checksum, Verify_Err, word index, read sum, byte counter.
  - count=0 → DONE; otherwise → COLLECT.
- COLLECT:
  - S_Ready=1.
  - Accepted byte k (0..3) goes to word bits [8k:8k+7]; the first byte lands in bits 0:7.
  - After byte 3 is accepted → WRITE.
  - S_Valid low: hold state, no change.
- WRITE:
  - S_Ready=0.
  - Drive EN=1, WEN=1111, Addr=base+4·index (32-bit add, wraps mod 2^32; no range check), Dout=word.
  - Checksum += word; index++.
  - If index reaches count: → VERIFY_RD when C_VERIFY=1, else → DONE.
  - Otherwise → COLLECT.
- VERIFY_RD:
  - Reset index to 0 on entry from WRITE.
  - Drive EN=1, WEN=0000, Addr=base+4·index → VERIFY_CMP.
- VERIFY_CMP:
  - EN=0; read sum += BRAM_Din_B; index++.
  - If more words → VERIFY_RD; else set Verify_Err = (read sum ≠ Checksum) → DONE.
- DONE: Done=1 for exactly one cycle → IDLE.
- Outside WRITE and VERIFY_RD: EN=0, WEN=0000. Addr and Dout hold their last values, with no functional meaning.
- Start while Busy is ignored.
- Rst at any point:
  - → IDLE; any partial word is discarded and no write is issued.
  - Outputs take reset values: S_Ready=0, EN=0, WEN=0000, Addr=0, Dout=0, Busy=0, Done=0, Verify_Err=0, Checksum=0.

## Timing
- Start high in cycle 0 (IDLE) → COLLECT in cycle 1, with S_Ready=1 in cycle 1.
- Continuous S_Valid: bytes are accepted in cycles 1–4 and the write happens in cycle 5. Word n (0-based) is written in cycle 5(n+1), giving 5 cycles per word.
- Verify: 2 cycles per word; the first VERIFY_RD is in cycle 5N+1.
- Done cycle:
  - C_VERIFY=1: Done in cycle 7N+1.
  - C_VERIFY=0: Done in cycle 5N+1.
  - N=0: Done in cycle 1, no BRAM access.
- Each cycle of S_Valid gap delays everything by one cycle.
- Read latency is assumed to be 1 cycle (the BRAM block's registered output).
- Busy rises the cycle after Start and falls the cycle after Done.

## Test plan
- Reset: assert Rst for 3 cycles mid-idle → all outputs at reset values; S_Ready=0 and no byte is consumed.
- Nominal load:
  - Stimulus: Base_Addr=0x00000100, Word_Count=2, bytes 01..08 back-to-back.
  - Writes: 0x01020304 @0x100 in cycle 5 and 0x05060708 @0x104 in cycle 10, each with WEN=1111.
  - Reads @0x100 then @0x104; Checksum=0x06080A0C; Verify_Err=0; Done in cycle 15.
- Backpressure: same load with S_Valid low on alternate cycles → identical writes and Checksum; no byte dropped or duplicated; no write before the 4th byte.
- Verify fault: the BRAM model flips bit 31 of the word returned @0x104 → Verify_Err=1 on Done; Checksum still 0x06080A0C.
- Edge cases:
  - Word_Count=0 → Done in cycle 1; EN never asserted.
  - Base_Addr=0xFFFFFFFC, Word_Count=2 → second write goes to 0x00000000.
  - Base_Addr=0x103 → first write goes to 0x100.
- Abort and restart:
  - Rst after 2 bytes of word 0 → no EN.
  - Start pulsed while Busy during the next load → ignored.
  - Next load with Base_Addr=0, Word_Count=1, bytes AA BB CC DD → 0xAABBCCDD @0x0.
